// File: rtl/alu_operand_loader.sv
// Byte-serial ALU front end: collects {A, B, opcode} from an RX byte stream, presents the operands
// to a combinational ALU, and returns the result as a single TX byte.
module alu_operand_loader #(
  parameter int N       = 7,
  parameter int OP_W    = 6,
  parameter int TIMEOUT = 1000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      RxData,
  input  logic            RxValid,
  output logic            RxReady,
  output logic [N-1:0]    BusA,
  output logic [N-1:0]    BusB,
  output logic [OP_W-1:0] OpCode,
  input  logic [N-1:0]    AluResult,
  output logic [7:0]      TxData,
  output logic            TxValid,
  input  logic            TxReady,
  output logic            Busy,
  output logic            FrameErr
);

  localparam int            CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_GET_A  = 3'd0,
    ST_GET_B  = 3'd1,
    ST_GET_OP = 3'd2,
    ST_EXEC   = 3'd3,
    ST_SEND   = 3'd4
  } state_t;

  state_t          state_r;
  state_t          next_state_s;
  logic [CW-1:0]   cnt_r;
  logic [CW-1:0]   cnt_next_s;
  logic            rx_xfer_s;
  logic            tx_xfer_s;
  logic            abort_s;
  logic            load_a_s;
  logic            load_b_s;
  logic            load_op_s;
  logic            load_tx_s;
  logic [7:0]      result_ext_s;
  logic [N-1:0]    bus_a_r;
  logic [N-1:0]    bus_b_r;
  logic [OP_W-1:0] opcode_r;
  logic [7:0]      tx_data_r;
  logic            tx_valid_r;
  logic            rx_ready_r;
  logic            busy_r;
  logic            frame_err_r;
  logic            rx_data_unused_s;

  // Upper RxData bits beyond the operand/opcode widths are intentionally dropped.
  assign rx_data_unused_s = ^RxData;

  assign rx_xfer_s = RxValid && rx_ready_r;
  assign tx_xfer_s = tx_valid_r && TxReady;

  // Zero-extend the ALU result into a full TX byte.
  always_comb begin
    result_ext_s        = 8'h00;
    result_ext_s[N-1:0] = AluResult;
  end

  // Next-state, load strobes and inter-byte timeout counter.
  always_comb begin
    next_state_s = state_r;
    cnt_next_s   = {CW{1'b0}};
    abort_s      = 1'b0;
    load_a_s     = 1'b0;
    load_b_s     = 1'b0;
    load_op_s    = 1'b0;
    load_tx_s    = 1'b0;
    case (state_r)
      ST_GET_A: begin
        if (rx_xfer_s) begin
          load_a_s     = 1'b1;
          next_state_s = ST_GET_B;
        end else begin
          next_state_s = ST_GET_A;
        end
      end
      ST_GET_B: begin
        // An accepted byte wins over a timeout expiring in the same cycle.
        if (rx_xfer_s) begin
          load_b_s     = 1'b1;
          next_state_s = ST_GET_OP;
        end else if (cnt_r == CNT_LAST) begin
          abort_s      = 1'b1;
          next_state_s = ST_GET_A;
        end else begin
          cnt_next_s   = cnt_r + CW'(1);
          next_state_s = ST_GET_B;
        end
      end
      ST_GET_OP: begin
        if (rx_xfer_s) begin
          load_op_s    = 1'b1;
          next_state_s = ST_EXEC;
        end else if (cnt_r == CNT_LAST) begin
          abort_s      = 1'b1;
          next_state_s = ST_GET_A;
        end else begin
          cnt_next_s   = cnt_r + CW'(1);
          next_state_s = ST_GET_OP;
        end
      end
      ST_EXEC: begin
        load_tx_s    = 1'b1;
        next_state_s = ST_SEND;
      end
      ST_SEND: begin
        if (tx_xfer_s) begin
          next_state_s = ST_GET_A;
        end else begin
          next_state_s = ST_SEND;
        end
      end
      default: begin
        next_state_s = ST_GET_A;
      end
    endcase
  end

  // State register and timeout counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_GET_A;
      cnt_r   <= {CW{1'b0}};
    end else begin
      state_r <= next_state_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Operand/opcode registers hold their last value, including across an aborted frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_a_r  <= {N{1'b0}};
      bus_b_r  <= {N{1'b0}};
      opcode_r <= {OP_W{1'b0}};
    end else begin
      if (load_a_s) begin
        bus_a_r <= RxData[N-1:0];
      end
      if (load_b_s) begin
        bus_b_r <= RxData[N-1:0];
      end
      if (load_op_s) begin
        opcode_r <= RxData[OP_W-1:0];
      end
    end
  end

  // Result byte is captured once in EXEC and held through SEND.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data_r <= 8'h00;
    end else if (load_tx_s) begin
      tx_data_r <= result_ext_s;
    end
  end

  // Handshake/status flags decoded from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_valid_r  <= 1'b0;
      rx_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      tx_valid_r  <= (next_state_s == ST_SEND);
      rx_ready_r  <= (next_state_s == ST_GET_A) || (next_state_s == ST_GET_B) ||
                     (next_state_s == ST_GET_OP);
      busy_r      <= (next_state_s != ST_GET_A);
      frame_err_r <= abort_s;
    end
  end

  assign RxReady  = rx_ready_r;
  assign BusA     = bus_a_r;
  assign BusB     = bus_b_r;
  assign OpCode   = opcode_r;
  assign TxData   = tx_data_r;
  assign TxValid  = tx_valid_r;
  assign Busy     = busy_r;
  assign FrameErr = frame_err_r;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader with a small combinational ALU attached to BusA/BusB/OpCode.
module tb_alu_operand_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] RxData = 8'h00;
  logic       RxValid = 1'b0;
  logic       RxReady;
  logic [6:0] BusA;
  logic [6:0] BusB;
  logic [5:0] OpCode;
  logic [6:0] AluResult;
  logic [7:0] TxData;
  logic       TxValid;
  logic       TxReady = 1'b1;
  logic       Busy;
  logic       FrameErr;

  int checks = 0;
  int errors = 0;

  alu_operand_loader #(.N(7), .OP_W(6), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .RxData(RxData), .RxValid(RxValid), .RxReady(RxReady),
    .BusA(BusA), .BusB(BusB), .OpCode(OpCode), .AluResult(AluResult),
    .TxData(TxData), .TxValid(TxValid), .TxReady(TxReady),
    .Busy(Busy), .FrameErr(FrameErr)
  );

  always #5 clk = ~clk;

  // MIPS-style function codes; shifts move BusA by one place.
  always_comb begin
    case (OpCode)
      6'h20:   AluResult = BusA + BusB;
      6'h22:   AluResult = BusA - BusB;
      6'h02:   AluResult = BusA >> 1;
      6'h03:   AluResult = {BusA[6], BusA[6:1]};
      6'h24:   AluResult = BusA & BusB;
      6'h25:   AluResult = BusA | BusB;
      default: AluResult = 7'h00;
    endcase
  end

  task automatic send_byte(input logic [7:0] b, output bit ok);
    int w;
    ok = 1'b0;
    w = 0;
    RxData = b;
    RxValid = 1'b1;
    while (!RxReady && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (RxReady) begin
      @(posedge clk);
      ok = 1'b1;
    end
    @(negedge clk);
    RxValid = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if ({BusA, BusB, OpCode, TxData, TxValid, FrameErr, Busy} !== 30'h0) begin
      errors++;
      $display("FAIL reset_outputs: got A=%h B=%h op=%h tx=%h v=%b fe=%b busy=%b, want all 0",
               BusA, BusB, OpCode, TxData, TxValid, FrameErr, Busy);
    end
    checks++;
    if (RxReady !== 1'b1) begin
      errors++;
      $display("FAIL reset_rxready: got %b want 1", RxReady);
    end
  endtask

  task automatic test_add;
    bit ok0, ok1, ok2;
    TxReady = 1'b1;
    send_byte(8'h05, ok0);
    send_byte(8'h03, ok1);
    send_byte(8'h20, ok2);
    checks++;
    if (!(ok0 && ok1 && ok2)) begin
      errors++;
      $display("FAIL add_accept: got ok=%b%b%b want 111", ok0, ok1, ok2);
    end
    // EXEC cycle: operands presented, result not yet offered
    checks++;
    if ({BusA, BusB, OpCode} !== {7'h05, 7'h03, 6'h20}) begin
      errors++;
      $display("FAIL add_operands: got %h/%h/%h want 05/03/20", BusA, BusB, OpCode);
    end
    checks++;
    if ({TxValid, RxReady, Busy} !== 3'b001) begin
      errors++;
      $display("FAIL add_exec_flags: got v/rdy/busy=%b%b%b want 001", TxValid, RxReady, Busy);
    end
    @(negedge clk);
    checks++;
    if ({TxValid, TxData} !== {1'b1, 8'h08}) begin
      errors++;
      $display("FAIL add_result: got v=%b data=%h want v=1 data=08", TxValid, TxData);
    end
    @(negedge clk);
    checks++;
    if ({TxValid, RxReady, Busy} !== 3'b010) begin
      errors++;
      $display("FAIL add_done: got v/rdy/busy=%b%b%b want 010", TxValid, RxReady, Busy);
    end
  endtask

  task automatic test_ops;
    logic [7:0] vec_a   [5] = '{8'h03, 8'h40, 8'h40, 8'hFF, 8'h15};
    logic [7:0] vec_b   [5] = '{8'h05, 8'h00, 8'h00, 8'h0F, 8'h0A};
    logic [7:0] vec_op  [5] = '{8'h22, 8'h03, 8'h02, 8'hE4, 8'h3F};
    logic [7:0] vec_exp [5] = '{8'h7E, 8'h60, 8'h20, 8'h0F, 8'h00};
    bit ok0, ok1, ok2;
    int w;
    TxReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send_byte(vec_a[i], ok0);
      send_byte(vec_b[i], ok1);
      send_byte(vec_op[i], ok2);
      w = 0;
      while (!TxValid && w < 10) begin
        @(negedge clk);
        w++;
      end
      checks++;
      if (!(ok0 && ok1 && ok2) || TxValid !== 1'b1 || TxData !== vec_exp[i] || w != 1) begin
        errors++;
        $display("FAIL op_%0d: got ok=%b%b%b v=%b data=%h lat=%0d want data=%h lat=1",
                 i, ok0, ok1, ok2, TxValid, TxData, w, vec_exp[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure;
    bit ok0, ok1, ok2;
    int w;
    int bad;
    TxReady = 1'b0;
    send_byte(8'h0A, ok0);
    send_byte(8'h05, ok1);
    send_byte(8'h20, ok2);
    w = 0;
    while (!TxValid && w < 10) begin
      @(negedge clk);
      w++;
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if ({TxValid, TxData, RxReady, Busy} !== {1'b1, 8'h0F, 1'b0, 1'b1}) bad++;
      @(negedge clk);
    end
    checks++;
    if (!(ok0 && ok1 && ok2) || bad != 0) begin
      errors++;
      $display("FAIL bp_hold: got %0d unstable cycles (v=%b data=%h) want 0, data 0F", bad,
               TxValid, TxData);
    end
    TxReady = 1'b1;
    @(negedge clk);
    TxReady = 1'b0;
    checks++;
    if ({TxValid, RxReady, Busy} !== 3'b010) begin
      errors++;
      $display("FAIL bp_release: got v/rdy/busy=%b%b%b want 010", TxValid, RxReady, Busy);
    end
    @(negedge clk);
    checks++;
    if (TxValid !== 1'b0) begin
      errors++;
      $display("FAIL bp_single: got TxValid=%b want 0", TxValid);
    end
    TxReady = 1'b1;
  endtask

  task automatic test_timeout;
    bit ok0, ok1, ok2;
    int n;
    int pulses;
    send_byte(8'h11, ok0);
    n = 0;
    while (FrameErr !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!ok0 || n != 16) begin
      errors++;
      $display("FAIL timeout_cycles: got FrameErr after %0d cycles want 16", n);
    end
    checks++;
    if ({Busy, RxReady, BusA} !== {1'b0, 1'b1, 7'h11}) begin
      errors++;
      $display("FAIL timeout_state: got busy=%b rdy=%b A=%h want 0 1 11", Busy, RxReady, BusA);
    end
    @(negedge clk);
    checks++;
    if (FrameErr !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse: got FrameErr=%b want 0", FrameErr);
    end
    send_byte(8'h01, ok0);
    send_byte(8'h01, ok1);
    send_byte(8'h25, ok2);
    @(negedge clk);
    checks++;
    if (!(ok0 && ok1 && ok2) || {TxValid, TxData, BusA} !== {1'b1, 8'h01, 7'h01}) begin
      errors++;
      $display("FAIL timeout_recover: got v=%b data=%h A=%h want 1 01 01", TxValid, TxData, BusA);
    end
    @(negedge clk);
    // byte B arriving on the last allowed cycle must beat the abort
    send_byte(8'h22, ok0);
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (FrameErr) pulses++;
    end
    send_byte(8'h11, ok1);
    if (FrameErr) pulses++;
    checks++;
    if (!(ok0 && ok1) || pulses != 0 || {Busy, RxReady} !== 2'b11 || BusB !== 7'h11) begin
      errors++;
      $display("FAIL timeout_edge: got pulses=%0d busy=%b rdy=%b B=%h want 0 1 1 11", pulses,
               Busy, RxReady, BusB);
    end
    send_byte(8'h20, ok2);
    @(negedge clk);
    checks++;
    if (!ok2 || {TxValid, TxData} !== {1'b1, 8'h33}) begin
      errors++;
      $display("FAIL timeout_edge_result: got v=%b data=%h want 1 33", TxValid, TxData);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midframe;
    bit ok0, ok1, ok2;
    int w;
    send_byte(8'h05, ok0);
    send_byte(8'h03, ok1);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({BusA, BusB, OpCode, TxData, TxValid, FrameErr, Busy, RxReady} !== 31'h1) begin
      errors++;
      $display("FAIL reset_midframe: got A=%h B=%h op=%h tx=%h v=%b fe=%b busy=%b rdy=%b",
               BusA, BusB, OpCode, TxData, TxValid, FrameErr, Busy, RxReady);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send_byte(8'h02, ok0);
    send_byte(8'h02, ok1);
    send_byte(8'h20, ok2);
    @(negedge clk);
    checks++;
    if (!(ok0 && ok1 && ok2) || {TxValid, TxData} !== {1'b1, 8'h04}) begin
      errors++;
      $display("FAIL reset_newframe: got v=%b data=%h want 1 04", TxValid, TxData);
    end
    @(negedge clk);
    TxReady = 1'b0;
    send_byte(8'h07, ok0);
    send_byte(8'h01, ok1);
    send_byte(8'h20, ok2);
    w = 0;
    while (!TxValid && w < 10) begin
      @(negedge clk);
      w++;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({TxValid, TxData, Busy, BusA} !== {1'b0, 8'h00, 1'b0, 7'h00}) begin
      errors++;
      $display("FAIL reset_midsend: got v=%b data=%h busy=%b A=%h want 0 00 0 00", TxValid,
               TxData, Busy, BusA);
    end
    @(negedge clk);
    rst_n = 1'b1;
    TxReady = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    @(negedge clk);
    test_reset;
    test_add;
    test_ops;
    test_backpressure;
    test_timeout;
    test_reset_midframe;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
